// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver feeding a first-word-fall-through FIFO, with sticky
// framing-error and overflow flags.
module uart_rx_fifo #(
  parameter int BAUD_DIV = 5208,
  parameter int ADDR_W   = 3
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              rx,
  input  logic              read,
  input  logic              clear_err,
  output logic [7:0]        data_out,
  output logic              data_ready,
  output logic [ADDR_W:0]   rx_count,
  output logic              frame_err,
  output logic              overflow,
  output logic [2:0]        state_dbg
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int TW    = $clog2(BAUD_DIV);
  localparam logic [TW-1:0] TMR_LAST = TW'(BAUD_DIV - 1);
  localparam logic [TW-1:0] TMR_HALF = TW'(BAUD_DIV / 2 - 1);
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_BREAK = 3'd4;

  logic          rx_meta;
  logic          rx_s;
  logic [2:0]    state;
  logic [TW-1:0] tmr;
  logic [2:0]    bitn;
  logic [7:0]    shreg;
  logic          tmr_done;
  logic          push_req;
  logic          ferr_set;

  logic [7:0]    mem [DEPTH];
  logic [ADDR_W:0] wr_ptr;
  logic [ADDR_W:0] rd_ptr;
  logic          fifo_full;
  logic          fifo_empty;
  logic          do_pop;
  logic          do_push;
  logic          ovf_set;

  // rx is asynchronous to clk; both stages idle high so reset looks like a quiet line.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  always_comb begin
    tmr_done = (tmr == TMR_LAST);
    push_req = (state == S_STOP) && tmr_done && rx_s;
    ferr_set = (state == S_STOP) && tmr_done && !rx_s;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= S_IDLE;
      tmr   <= '0;
      bitn  <= '0;
      shreg <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          tmr  <= '0;
          bitn <= '0;
          if (!rx_s) state <= S_START;
        end
        S_START: begin
          // Mid-start-bit check rejects glitches shorter than half a bit.
          if (tmr == TMR_HALF) begin
            tmr   <= '0;
            bitn  <= '0;
            state <= rx_s ? S_IDLE : S_DATA;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        S_DATA: begin
          if (tmr_done) begin
            tmr         <= '0;
            shreg[bitn] <= rx_s;
            bitn        <= bitn + 1'b1;
            if (bitn == 3'd7) state <= S_STOP;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        S_STOP: begin
          if (tmr_done) begin
            tmr   <= '0;
            state <= rx_s ? S_IDLE : S_BREAK;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        S_BREAK: begin
          // A held-low line must return high before another start bit counts.
          tmr <= '0;
          if (rx_s) state <= S_IDLE;
        end
        default: begin
          tmr   <= '0;
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign state_dbg = state;

  // Consumer handshake: data_out is valid whenever data_ready is high; a cycle
  // with read high and data_ready high pops exactly one entry, read while empty
  // is ignored.
  always_comb begin
    rx_count   = wr_ptr - rd_ptr;
    fifo_full  = (rx_count == FULL_CNT);
    fifo_empty = (rx_count == '0);
    do_pop     = read && !fifo_empty;
    do_push    = push_req && (!fifo_full || do_pop);
    ovf_set    = push_req && fifo_full && !do_pop;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_push) begin
      mem[wr_ptr[ADDR_W-1:0]] <= shreg;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  assign data_out   = mem[rd_ptr[ADDR_W-1:0]];
  assign data_ready = !fifo_empty;

  // Set has priority over clear_err so an error in the clearing cycle is kept.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      frame_err <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (ferr_set)       frame_err <= 1'b1;
      else if (clear_err) frame_err <= 1'b0;
      if (ovf_set)        overflow  <= 1'b1;
      else if (clear_err) overflow  <= 1'b0;
    end
  end

endmodule
